// File: rtl/mem_pkg.sv
// Shared memory-access definitions: RISC-V load/store funct3 encodings and
// the responder state type, also used by the CPU control and ALU-control units.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_align.sv
// Combinational lane logic for byte/halfword/word accesses: alignment and
// funct3 checking, store byte enables and lane replication, load extraction.
module mem_align
    import mem_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    input  logic        is_write,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  wmask,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        error
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword[{addr, 3'b000} +: 8];
    assign rhalf = addr[1] ? rword[31:16] : rword[15:0];

    // The unsigned encodings exist only for loads, so they are errors on stores.
    always_comb begin
        error = 1'b0;
        case (funct3)
            F3_B:    error = 1'b0;
            F3_H:    error = addr[0];
            F3_W:    error = (addr != 2'b00);
            F3_BU:   error = is_write;
            F3_HU:   error = is_write | addr[0];
            default: error = 1'b1;
        endcase
    end

    always_comb begin
        wmask = 4'b0000;
        wword = wdata;
        rdata = '0;
        case (funct3)
            F3_B: begin
                wmask = 4'b0001 << addr;
                wword = {4{wdata[7:0]}};
                rdata = {{24{rbyte[7]}}, rbyte};
            end
            F3_H: begin
                wmask = addr[1] ? 4'b1100 : 4'b0011;
                wword = {2{wdata[15:0]}};
                rdata = {{16{rhalf[15]}}, rhalf};
            end
            F3_W: begin
                wmask = 4'b1111;
                rdata = rword;
            end
            F3_BU:   rdata = {24'b0, rbyte};
            F3_HU:   rdata = {16'b0, rhalf};
            default: ;
        endcase
        if (error || !is_write) wmask = 4'b0000;
        if (error || is_write) rdata = '0;
    end

endmodule

// File: rtl/data_memory_responder.sv
// Multi-cycle data-memory slave with valid/ready request and response channels,
// one outstanding request, and a fixed accept-to-response latency.
module data_memory_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int         AW     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t      state, state_next;
    logic [3:0]  count;
    logic        lat_write;
    logic [AW+1:0] lat_addr;
    logic [2:0]  lat_funct3;
    logic [31:0] lat_wdata;
    logic [31:0] mem [DEPTH_WORDS];

    logic        accept, do_access;
    logic        acc_write;
    logic [AW+1:0] acc_addr;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_wdata;
    logic [31:0] rword, wword, rdata;
    logic [3:0]  wmask;
    logic        error;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^req_addr[31:AW+2];

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign accept     = req_valid && req_ready;

    // With LATENCY = 1 the access happens on the accept edge itself, so the
    // lane logic sees the live request in IDLE and the latched one otherwise.
    assign do_access  = (accept && (LAT_M1 == 4'd0)) || ((state == WAIT) && (count == 4'd1));
    assign acc_write  = (state == IDLE) ? req_write  : lat_write;
    assign acc_addr   = (state == IDLE) ? req_addr[AW+1:0] : lat_addr;
    assign acc_funct3 = (state == IDLE) ? req_funct3 : lat_funct3;
    assign acc_wdata  = (state == IDLE) ? req_wdata  : lat_wdata;
    assign rword      = mem[acc_addr[AW+1:2]];

    mem_align u_align (
        .addr     (acc_addr[1:0]),
        .funct3   (acc_funct3),
        .is_write (acc_write),
        .wdata    (acc_wdata),
        .rword    (rword),
        .wmask    (wmask),
        .wword    (wword),
        .rdata    (rdata),
        .error    (error)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = (LAT_M1 == 4'd0) ? RESP : WAIT;
            WAIT:    if (do_access) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_funct3 <= '0;
            lat_wdata  <= '0;
            resp_rdata <= '0;
            resp_error <= 1'b0;
        end else begin
            if (accept) begin
                lat_write  <= req_write;
                lat_addr   <= req_addr[AW+1:0];
                lat_funct3 <= req_funct3;
                lat_wdata  <= req_wdata;
                count      <= LAT_M1;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (do_access) begin
                resp_rdata <= rdata;
                resp_error <= error;
            end
        end
    end

    // Reset wins over a pending access, so an aborted store never lands.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else if (do_access) begin
            for (int b = 0; b < 4; b++)
                if (wmask[b]) mem[acc_addr[AW+1:2]][8*b +: 8] <= wword[8*b +: 8];
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: one instance at LATENCY 2 and
// one at LATENCY 1 share the request fields and are selected by 'sel'.
module tb_data_memory_responder;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        error;
    } resp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        resp_ready;
    logic        req_valid2, req_ready2, resp_valid2, resp_error2;
    logic        req_valid1, req_ready1, resp_valid1, resp_error1;
    logic [31:0] resp_rdata2, resp_rdata1;
    logic        sel;
    logic        o_req_ready, o_resp_valid, o_resp_error;
    logic [31:0] o_resp_rdata;

    resp_t exp_q[$];
    int    n_checks = 0;
    int    n_fails  = 0;

    always #5 clk = ~clk;

    assign o_req_ready  = sel ? req_ready1  : req_ready2;
    assign o_resp_valid = sel ? resp_valid1 : resp_valid2;
    assign o_resp_rdata = sel ? resp_rdata1 : resp_rdata2;
    assign o_resp_error = sel ? resp_error1 : resp_error2;

    data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid2), .req_ready(req_ready2),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid2), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata2), .resp_error(resp_error2)
    );

    data_memory_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata1), .resp_error(resp_error1)
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic setValid(input logic v);
        if (sel) req_valid1 = v;
        else     req_valid2 = v;
    endtask

    // Drives one request, pushes its expected response, then pops and compares
    // when the response appears; hold > 0 stalls resp_ready for that many cycles.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [2:0] f3,
                                 input logic [31:0] wd, input logic [31:0] er, input logic ee,
                                 input int hold, input string tag);
        resp_t e, got;
        int    cyc;
        int    lat;
        lat = sel ? 1 : 2;
        e.rdata = er;
        e.error = ee;
        exp_q.push_back(e);
        @(negedge clk);
        req_write  = w;
        req_addr   = a;
        req_funct3 = f3;
        req_wdata  = wd;
        resp_ready = (hold == 0);
        setValid(1'b1);
        checkOutput({tag, ".req_ready_idle"}, 32'(o_req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_write  = 1'($urandom_range(0, 1));
        req_addr   = $urandom;
        req_funct3 = 3'($urandom_range(0, 7));
        req_wdata  = $urandom;
        cyc = 1;
        while (!o_resp_valid && cyc < 20) begin
            checkOutput({tag, ".req_ready_wait"}, 32'(o_req_ready), 32'd0);
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, ".latency"}, 32'(cyc), 32'(lat));
        if (exp_q.size() == 0) begin
            checkOutput({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
            got.rdata = '0;
            got.error = 1'b0;
        end else begin
            got = exp_q.pop_front();
        end
        checkOutput({tag, ".rdata"}, o_resp_rdata, got.rdata);
        checkOutput({tag, ".error"}, 32'(o_resp_error), 32'(got.error));
        checkOutput({tag, ".req_ready_resp"}, 32'(o_req_ready), 32'd0);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            checkOutput({tag, ".hold_valid"}, 32'(o_resp_valid), 32'd1);
            checkOutput({tag, ".hold_req_ready"}, 32'(o_req_ready), 32'd0);
            checkOutput({tag, ".hold_rdata"}, o_resp_rdata, got.rdata);
            checkOutput({tag, ".hold_error"}, 32'(o_resp_error), 32'(got.error));
        end
        resp_ready = 1'b1;
        @(negedge clk);
        setValid(1'b0);
        checkOutput({tag, ".req_ready_after"}, 32'(o_req_ready), 32'd1);
        checkOutput({tag, ".valid_after"}, 32'(o_resp_valid), 32'd0);
    endtask

    initial begin
        reset      = 1'b1;
        sel        = 1'b0;
        req_valid2 = 1'b0;
        req_valid1 = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_funct3 = '0;
        req_wdata  = '0;
        resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("reset.req_ready", 32'(req_ready2), 32'd1);
        checkOutput("reset.resp_valid", 32'(resp_valid2), 32'd0);
        checkOutput("reset.rdata", resp_rdata2, 32'd0);
        checkOutput("reset.error", 32'(resp_error2), 32'd0);
        checkOutput("reset.req_ready1", 32'(req_ready1), 32'd1);
        checkOutput("reset.resp_valid1", 32'(resp_valid1), 32'd0);

        applyStimulus(1, 32'h10, F3_W, 32'hDEADBEEF, 32'h0, 0, 0, "sw_10");
        applyStimulus(0, 32'h10, F3_W, 32'h0, 32'hDEADBEEF, 0, 0, "lw_10");
        applyStimulus(1, 32'h11, F3_B, 32'h000000AA, 32'h0, 0, 0, "sb_11");
        applyStimulus(0, 32'h10, F3_W, 32'h0, 32'hDEADAAEF, 0, 0, "lw_10_sb");
        applyStimulus(0, 32'h11, F3_B, 32'h0, 32'hFFFFFFAA, 0, 0, "lb_11");
        applyStimulus(0, 32'h11, F3_BU, 32'h0, 32'h000000AA, 0, 4, "lbu_11_bp");
        applyStimulus(0, 32'h12, F3_H, 32'h0, 32'hFFFFDEAD, 0, 0, "lh_12");
        applyStimulus(0, 32'h12, F3_HU, 32'h0, 32'h0000DEAD, 0, 0, "lhu_12");
        applyStimulus(0, 32'h13, F3_W, 32'h0, 32'h0, 1, 0, "lw_13_mis");
        applyStimulus(1, 32'h11, F3_H, 32'h00001234, 32'h0, 1, 0, "sh_11_mis");
        applyStimulus(0, 32'h10, F3_W, 32'h0, 32'hDEADAAEF, 0, 0, "lw_10_keep");
        applyStimulus(0, 32'h10, 3'd3, 32'h0, 32'h0, 1, 0, "ld_f3_3");
        applyStimulus(1, 32'h10, F3_BU, 32'h11111111, 32'h0, 1, 0, "st_f3_4");
        applyStimulus(0, 32'h10, F3_W, 32'h0, 32'hDEADAAEF, 0, 0, "lw_10_keep2");
        applyStimulus(1, 32'h12, F3_H, 32'h0000BEEF, 32'h0, 0, 0, "sh_12");
        applyStimulus(0, 32'h10, F3_W, 32'h0, 32'hBEEFAAEF, 0, 0, "lw_10_sh");
        applyStimulus(1, 32'h1000, F3_W, 32'h12345678, 32'h0, 0, 0, "sw_1000");
        applyStimulus(0, 32'h0, F3_W, 32'h0, 32'h12345678, 0, 0, "lw_0_wrap");

        // Reset lands in the WAIT cycle of a store; the store must never commit.
        @(negedge clk);
        req_write  = 1'b1;
        req_addr   = 32'h20;
        req_funct3 = F3_W;
        req_wdata  = 32'h55;
        req_valid2 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid2 = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort.req_ready", 32'(req_ready2), 32'd1);
        checkOutput("abort.resp_valid", 32'(resp_valid2), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abort.no_resp", 32'(resp_valid2), 32'd0);
        end
        applyStimulus(0, 32'h20, F3_W, 32'h0, 32'h0, 0, 0, "lw_20_abort");

        sel = 1'b1;
        applyStimulus(1, 32'h4, F3_W, 32'hCAFEF00D, 32'h0, 0, 0, "l1_sw_4");
        applyStimulus(0, 32'h4, F3_W, 32'h0, 32'hCAFEF00D, 0, 0, "l1_lw_4");
        applyStimulus(0, 32'h6, F3_HU, 32'h0, 32'h0000CAFE, 0, 2, "l1_lhu_6");
        applyStimulus(0, 32'h4, F3_B, 32'h0, 32'h0000000D, 0, 0, "l1_lb_4");
        applyStimulus(0, 32'h5, F3_H, 32'h0, 32'h0, 1, 0, "l1_lh_5_mis");

        checkOutput("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
